// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// It captures the decoded bundle into the EX stage and inserts one bubble per
// load-use hazard. Flush and hold from downstream are honoured. A saturating
// counter records how many hazard bubbles were inserted.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm_ext,
  input  logic [DW-1:0] id_pc_plus4,
  input  logic [1:0]    id_jump,
  input  logic [1:0]    id_alu_src_a,
  input  logic [1:0]    id_alu_src_b,
  input  logic [1:0]    id_reg_dst,
  input  logic [1:0]    id_mem_to_reg,
  input  logic [3:0]    id_alu_op,
  input  logic          id_branch,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          ex_flush,
  input  logic          ex_hold,
  output logic          ex_valid,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [4:0]    ex_shamt,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm_ext,
  output logic [DW-1:0] ex_pc_plus4,
  output logic [1:0]    ex_jump,
  output logic          ex_branch,
  output logic          ex_reg_write,
  output logic [1:0]    ex_alu_src_a,
  output logic [1:0]    ex_alu_src_b,
  output logic [3:0]    ex_alu_op,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [1:0]    ex_mem_to_reg,
  output logic [4:0]    ex_write_reg,
  output logic          stall_if_id,
  output logic [CW-1:0] hazard_bubbles
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] pc_plus4;
    logic [1:0]    jump;
    logic          branch;
    logic          reg_write;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [3:0]    alu_op;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_to_reg;
    logic [4:0]    write_reg;
  } ex_bundle_t;

  ex_bundle_t ex_q;
  ex_bundle_t cap;
  logic [4:0] dst;
  logic       uses_rs;
  logic       uses_rt;
  logic       load_use;

  // Destination select happens here, so EX sees a ready register number.
  always_comb begin
    dst = 5'd31;
    case (id_reg_dst)
      2'b00:   dst = id_rd;
      2'b11:   dst = id_rt;
      default: dst = 5'd31;
    endcase
  end

  // Capture bundle. An invalid ID slot keeps its data but gets no enables.
  always_comb begin
    cap            = '0;
    cap.valid      = id_valid;
    cap.rs         = id_rs;
    cap.rt         = id_rt;
    cap.rd         = id_rd;
    cap.shamt      = id_shamt;
    cap.rs_data    = id_rs_data;
    cap.rt_data    = id_rt_data;
    cap.imm_ext    = id_imm_ext;
    cap.pc_plus4   = id_pc_plus4;
    cap.jump       = id_valid ? id_jump : 2'b00;
    cap.branch     = id_valid & id_branch;
    cap.reg_write  = id_valid & id_reg_write;
    cap.alu_src_a  = id_alu_src_a;
    cap.alu_src_b  = id_alu_src_b;
    cap.alu_op     = id_alu_op;
    cap.mem_read   = id_valid & id_mem_read;
    cap.mem_write  = id_valid & id_mem_write;
    cap.mem_to_reg = id_mem_to_reg;
    cap.write_reg  = dst;
  end

  // Load in EX whose target is read by the ID instruction; $0 never hazards.
  always_comb begin
    uses_rs  = (id_alu_src_a == 2'b10) | (id_jump == 2'b01);
    uses_rt  = (id_alu_src_b == 2'b11) | id_mem_write;
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & id_valid &
               ((uses_rs & (ex_q.rt == id_rs)) | (uses_rt & (ex_q.rt == id_rt)));
  end

  // A flush kills the ID instruction, so there is nothing to hold for.
  assign stall_if_id = (load_use | ex_hold) & ~ex_flush;

  // EX register: reset > flush > hold > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (!reset)        ex_q <= '0;
    else if (ex_flush) ex_q <= '0;
    else if (ex_hold)  ex_q <= ex_q;
    else if (load_use) ex_q <= '0;
    else               ex_q <= cap;
  end

  // Counts only bubbles that load-use actually inserted; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset)
      hazard_bubbles <= '0;
    else if (!ex_flush && !ex_hold && load_use && (hazard_bubbles != {CW{1'b1}}))
      hazard_bubbles <= hazard_bubbles + CW'(1);
  end

  assign ex_valid      = ex_q.valid;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_shamt      = ex_q.shamt;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm_ext    = ex_q.imm_ext;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_jump       = ex_q.jump;
  assign ex_branch     = ex_q.branch;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_alu_src_a  = ex_q.alu_src_a;
  assign ex_alu_src_b  = ex_q.alu_src_b;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_write_reg  = ex_q.write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, saturation run and random
// traffic compared against a behavioural model of the EX register.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_branch, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4;
  logic [1:0] id_jump, id_alu_src_a, id_alu_src_b, id_reg_dst, id_mem_to_reg;
  logic [3:0] id_alu_op;
  logic ex_flush, ex_hold;

  logic ex_valid, ex_branch, ex_reg_write, ex_mem_read, ex_mem_write, stall_if_id;
  logic [4:0] ex_rs, ex_rt, ex_rd, ex_shamt, ex_write_reg;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4;
  logic [1:0] ex_jump, ex_alu_src_a, ex_alu_src_b, ex_mem_to_reg;
  logic [3:0] ex_alu_op;
  logic [CW-1:0] hazard_bubbles;

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm_ext(id_imm_ext), .id_pc_plus4(id_pc_plus4),
    .id_jump(id_jump), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
    .id_reg_dst(id_reg_dst), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .id_branch(id_branch), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm_ext(ex_imm_ext), .ex_pc_plus4(ex_pc_plus4), .ex_jump(ex_jump),
    .ex_branch(ex_branch), .ex_reg_write(ex_reg_write),
    .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b),
    .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
    .stall_if_id(stall_if_id), .hazard_bubbles(hazard_bubbles)
  );

  // Behavioural picture of what EX should hold.
  typedef struct {
    bit valid; bit [4:0] rs, rt, rd, shamt;
    bit [DW-1:0] rs_data, rt_data, imm, pc;
    bit [1:0] jump; bit branch, reg_write; bit [1:0] asa, asb;
    bit [3:0] alu_op; bit mem_read, mem_write; bit [1:0] m2r; bit [4:0] wr;
  } ex_t;

  ex_t m;
  int  m_bub;
  int  passed = 0;
  int  total  = 0;

  typedef struct {
    bit rst, vld; bit [4:0] rs, rt, rd; bit [1:0] asa, asb, jmp, dst;
    bit mr, mw, rw, fl, hd;
    bit e_stall, e_valid; bit [4:0] e_wr; bit e_mr; int e_bub;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [255:0] dut_vec();
    return 256'({ex_valid, ex_rs, ex_rt, ex_rd, ex_shamt, ex_rs_data, ex_rt_data,
                 ex_imm_ext, ex_pc_plus4, ex_jump, ex_branch, ex_reg_write,
                 ex_alu_src_a, ex_alu_src_b, ex_alu_op, ex_mem_read, ex_mem_write,
                 ex_mem_to_reg, ex_write_reg});
  endfunction

  function automatic logic [255:0] mdl_vec();
    return 256'({m.valid, m.rs, m.rt, m.rd, m.shamt, m.rs_data, m.rt_data, m.imm, m.pc,
                 m.jump, m.branch, m.reg_write, m.asa, m.asb, m.alu_op,
                 m.mem_read, m.mem_write, m.m2r, m.wr});
  endfunction

  // Does the ID instruction read the register the EX load is about to write?
  function automatic bit model_hazard();
    bit reads_rs, reads_rt;
    if (!(m.valid && m.mem_read && m.rt != 0 && id_valid)) return 1'b0;
    reads_rs = (id_alu_src_a == 2'b10) || (id_jump == 2'b01);
    reads_rt = (id_alu_src_b == 2'b11) || id_mem_write;
    return (reads_rs && m.rt == id_rs) || (reads_rt && m.rt == id_rt);
  endfunction

  function automatic ex_t model_capture();
    ex_t c;
    c = '{default: '0};
    c.valid = id_valid; c.rs = id_rs; c.rt = id_rt; c.rd = id_rd; c.shamt = id_shamt;
    c.rs_data = id_rs_data; c.rt_data = id_rt_data; c.imm = id_imm_ext; c.pc = id_pc_plus4;
    c.asa = id_alu_src_a; c.asb = id_alu_src_b; c.alu_op = id_alu_op; c.m2r = id_mem_to_reg;
    if (id_valid) begin
      c.jump = id_jump; c.branch = id_branch; c.reg_write = id_reg_write;
      c.mem_read = id_mem_read; c.mem_write = id_mem_write;
    end
    if (id_reg_dst == 2'b00)      c.wr = id_rd;
    else if (id_reg_dst == 2'b11) c.wr = id_rt;
    else                          c.wr = 5'd31;
    return c;
  endfunction

  task automatic rand_data();
    id_shamt = 5'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm_ext = $urandom; id_pc_plus4 = $urandom; id_alu_op = 4'($urandom);
    id_branch = 1'($urandom); id_mem_to_reg = 2'($urandom);
  endtask

  // One clock: check the combinational stall, advance the model, compare EX.
  task automatic step(output logic st);
    bit   hz, exp_st;
    ex_t  nm;
    int   nb;
    #1;
    hz     = model_hazard();
    exp_st = (hz || ex_hold) && !ex_flush;
    st     = stall_if_id;
    chk("stall_if_id", 256'(stall_if_id), 256'(exp_st));
    nm = m; nb = m_bub;
    if (!reset) begin nm = '{default: '0}; nb = 0; end
    else if (ex_flush) nm = '{default: '0};
    else if (ex_hold) nm = m;
    else if (hz) begin nm = '{default: '0}; nb = (m_bub < 15) ? m_bub + 1 : 15; end
    else nm = model_capture();
    @(posedge clk);
    m = nm; m_bub = nb;
    #1;
    chk("ex_bundle", dut_vec(), mdl_vec());
    chk("hazard_bubbles", 256'(hazard_bubbles), 256'(m_bub));
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_alu_src_a = v.asa; id_alu_src_b = v.asb; id_jump = v.jmp; id_reg_dst = v.dst;
    id_mem_read = v.mr; id_mem_write = v.mw; id_reg_write = v.rw;
    ex_flush = v.fl; ex_hold = v.hd;
    rand_data();
  endtask

  vec_t tbl[26];
  vec_t lw8, rdep8;
  logic st;

  initial begin
    // rst vld rs rt rd asa asb jmp dst mr mw rw fl hd | stall valid wr mr bub
    tbl = '{
      '{0,1, 1,8, 0, 2,1,0,3, 1,0,1, 0,0,  0,0, 0,0,0},  // reset with lw active
      '{0,1, 1,8, 0, 2,1,0,3, 1,0,1, 0,0,  0,0, 0,0,0},
      '{1,1, 1,8, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 8,1,0},  // lw $8 captured
      '{1,1, 8,4,10, 2,3,0,0, 0,0,1, 0,0,  1,0, 0,0,1},  // R uses $8 -> bubble
      '{1,1, 8,4,10, 2,3,0,0, 0,0,1, 0,0,  0,1,10,0,1},  // R issues
      '{1,1, 1,0, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 0,1,1},  // lw $0
      '{1,1, 0,0, 7, 2,3,0,0, 0,0,1, 0,0,  0,1, 7,0,1},  // reads $0: no hazard
      '{1,1, 1,9, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 9,1,1},  // lw $9
      '{1,1, 2,9, 0, 2,1,0,3, 0,0,1, 0,0,  0,1, 9,0,1},  // addi rt=9 unused
      '{1,1, 1,8, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 8,1,1},  // lw $8
      '{1,1, 8,4,10, 2,3,0,0, 0,0,1, 1,1,  0,0, 0,0,1},  // flush+hold+hazard
      '{1,1, 0,0, 0, 0,0,2,2, 0,0,1, 0,0,  0,1,31,0,1},  // jal -> $31
      '{1,1, 1,6, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 6,1,1},  // lw $6
      '{1,1, 6,4,11, 2,3,0,0, 0,0,1, 0,1,  1,1, 6,1,1},  // hold+hazard keeps lw
      '{1,1, 6,4,11, 2,3,0,0, 0,0,1, 0,0,  1,0, 0,0,2},  // now bubble
      '{1,1, 6,4,11, 2,3,0,0, 0,0,1, 0,0,  0,1,11,0,2},
      '{1,0, 1,8, 0, 2,1,0,3, 1,0,1, 0,0,  0,0, 8,0,2},  // invalid lw: data only
      '{1,1, 8,4,12, 2,3,0,0, 0,0,1, 0,0,  0,1,12,0,2},  // no hazard vs invalid
      '{1,1, 1,5, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 5,1,2},  // lw $5
      '{0,1, 5,4,13, 2,3,0,0, 0,0,1, 0,0,  1,0, 0,0,0},  // reset mid-stall
      '{1,1, 1,3, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 3,1,0},  // lw $3
      '{1,1, 3,0, 0, 0,0,1,0, 0,0,0, 0,0,  1,0, 0,0,1},  // jr $3 -> bubble
      '{1,1, 3,0, 0, 0,0,1,0, 0,0,0, 0,0,  0,1, 0,0,1},
      '{1,1, 1,3, 0, 2,1,0,3, 1,0,1, 0,0,  0,1, 3,1,1},  // lw $3
      '{1,1, 1,3, 0, 2,1,0,0, 0,1,0, 0,0,  1,0, 0,0,2},  // sw stores $3
      '{1,1, 1,3, 0, 2,1,0,0, 0,1,0, 0,0,  0,1, 0,0,2}
    };

    // Bring the DUT to a known state before the counted vectors.
    drive('{0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0});
    @(posedge clk); #1;
    m = '{default: '0}; m_bub = 0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step(st);
      chk($sformatf("tbl%0d_stall", i), 256'(st), 256'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_valid", i), 256'(ex_valid), 256'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_write_reg", i), 256'(ex_write_reg), 256'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_mem_read", i), 256'(ex_mem_read), 256'(tbl[i].e_mr));
      chk($sformatf("tbl%0d_bubbles", i), 256'(hazard_bubbles), 256'(tbl[i].e_bub));
    end

    // Saturation: 20 more hazards on top of the 2 already counted.
    lw8   = '{1,1, 1,8, 0, 2,1,0,3, 1,0,1, 0,0, 0,0,0,0,0};
    rdep8 = '{1,1, 8,4,10, 2,3,0,0, 0,0,1, 0,0, 0,0,0,0,0};
    for (int k = 0; k < 20; k++) begin
      drive(lw8);   step(st);
      drive(rdep8); step(st);
      step(st);
    end
    chk("saturate", 256'(hazard_bubbles), 256'(15));

    // Random traffic on a few registers so hazards collide often.
    for (int k = 0; k < 600; k++) begin
      reset        = ($urandom_range(0, 59) != 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom);
      id_alu_src_a = 2'($urandom); id_alu_src_b = 2'($urandom);
      id_jump      = 2'($urandom); id_reg_dst   = 2'($urandom);
      id_mem_read  = 1'($urandom); id_mem_write = ($urandom_range(0, 3) == 0);
      id_reg_write = 1'($urandom);
      ex_flush     = ($urandom_range(0, 9) == 0);
      ex_hold      = ($urandom_range(0, 5) == 0);
      rand_data();
      step(st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary directly downstream of the decode controller.
- Each cycle it captures the decoded control bundle, register operands, immediate and PC+4 into the EX-stage register. It also computes the EX write-destination register.
- Detects load-use hazards and inserts one bubble per hazard, stalling PC and IF/ID.
- Accepts branch/jump flush and downstream hold. Keeps a saturating hazard-bubble counter.

Parameters:
- DW, 32, datapath width (operands, immediate, PC+4)
- CW, 16, width of hazard-bubble counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_shamt  in  5  shift amount
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm_ext  in  DW  extended/lui-shifted immediate
- id_pc_plus4  in  DW  PC+4 of ID instruction
- id_jump, id_alu_src_a, id_alu_src_b, id_reg_dst, id_mem_to_reg  in  2 each  decoded controls
- id_alu_op  in  4  decoded ALU op
- id_branch, id_reg_write, id_mem_read, id_mem_write  in  1 each  decoded controls
- ex_flush  in  1  branch/jump resolved taken; kill ID instruction
- ex_hold  in  1  downstream not ready; freeze EX register
- ex_valid  out  1  EX register holds a real instruction
- ex_* (rs, rt, rd, shamt, rs_data, rt_data, imm_ext, pc_plus4, jump, branch, reg_write, alu_src_a, alu_src_b, alu_op, mem_read, mem_write, mem_to_reg)  out  same widths as id_*  registered copies
- ex_write_reg  out  5  registered destination: reg_dst 00 -> rd, 11 -> rt, 01/10 -> 31
- stall_if_id  out  1  combinational; hold PC and IF/ID this cycle
- hazard_bubbles  out  CW  saturating count of load-use bubbles

Behaviour:
- Reset (reset==0 at edge): every ex_* output, ex_valid, ex_write_reg and hazard_bubbles go to 0. The reset cycle is a bubble. Reset overrides all other inputs, including mid-stall.
- ex_write_reg is computed from id_reg_dst at capture and registered with the bundle; it is not decoded in EX.
- Hazard, combinational: load_use = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
  - uses_rs = (id_alu_src_a==2'b10) | (id_jump==2'b01).
  - uses_rt = (id_alu_src_b==2'b11) | id_mem_write.
- stall_if_id = (load_use | ex_hold) & ~ex_flush.
- Per-edge priority, highest first:
  1. reset
  2. ex_flush: load bubble
  3. ex_hold: keep all EX outputs unchanged
  4. load_use: load bubble
  5. otherwise capture all id_* inputs, with ex_valid = id_valid
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch=0 and ex_jump=00. All other ex_* fields go to 0.
- If id_valid=0 during a capture, the enables are forced to 0 exactly as for a bubble; the data fields are still captured.
- Single bubble: after a load-use bubble, ex_mem_read=0, so load_use drops the next cycle. The held instruction then issues, and MEM/WB forwarding covers the dependency. Latency ID->EX is 1 cycle, plus 1 per hazard.
- hazard_bubbles increments by 1 only on edges where priority 4 loads a bubble. It saturates at 2^CW-1 and never wraps. Flush and hold do not count.
- Simultaneous events:
  - flush+hold: flush wins; stall_if_id=0.
  - flush+load_use: flush wins; no count.
  - hold+load_use: hold wins; EX keeps the load, stall_if_id=1, no count.

Test Plan:
- Reset: hold reset=0 for 2 cycles with id inputs active -> all ex_* =0, hazard_bubbles=0, stall_if_id=0. Release reset -> the next edge captures id_*.
- Load-use stall: EX holds lw (ex_rt=8, ex_mem_read=1, ex_valid=1); ID is R-type with id_rs=8, alu_src_b=11 -> stall_if_id=1. The next edge gives a bubble (ex_valid=0, ex_reg_write=0) and hazard_bubbles=1. The following edge captures the R-type with ex_write_reg=id_rd.
- No hazard on $0 or an unused rt: lw with ex_rt=0 gives stall_if_id=0. lw ex_rt=9 with ID addi (alu_src_b=01) and id_rt=9 also gives stall_if_id=0.
- Flush priority: ex_flush=1 together with load_use=1 and ex_hold=1 -> stall_if_id=0. The next edge gives a bubble, and hazard_bubbles is unchanged.
- Destination select: jal with reg_dst=10 -> ex_write_reg=31. lw with reg_dst=11 and id_rt=5 -> ex_write_reg=5.
- Saturation: CW=4 with 20 consecutive load-use hazards (ID refilled each time) -> hazard_bubbles stops at 15.
